// File: rtl/jtframe_obj_pkg.sv
// Shared definitions for the object row renderer: FSM encoding and pixel packing.
package jtframe_obj_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAW  = 2'd2
    } state_t;

    localparam int PIX_W        = 4;
    localparam int PIX_PER_WORD = 8;

endpackage

// File: rtl/jtframe_obj_draw_shift.sv
// 32-bit pixel shift register. The nibble output already sees the incoming word on a
// load cycle, so the first pixel of a word can be registered on the same edge as the load.
module jtframe_obj_draw_shift
    import jtframe_obj_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic             rev,
    input  logic [31:0]      din,
    output logic [PIX_W-1:0] nibble
);

    logic [31:0] sr_reg;
    logic [31:0] src;

    always_comb begin
        src    = load ? din : sr_reg;
        nibble = rev ? src[PIX_W-1:0] : src[31 -: PIX_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_reg <= '0;
        end else if (load || shift) begin
            sr_reg <= rev ? (src >> PIX_W) : (src << PIX_W);
        end
    end

endmodule

// File: rtl/jtframe_obj_draw.sv
// Sprite row renderer: fetches one 16-pixel row as two ROM words and writes it,
// one palette-tagged pixel per clock, into the object line buffer.
module jtframe_obj_draw
    import jtframe_obj_pkg::*;
#(
    parameter int CW = 12,
    parameter int PW = 4,
    parameter int AW = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              draw,
    output logic              busy,
    input  logic [CW-1:0]     code,
    input  logic [AW-1:0]     xpos,
    input  logic [3:0]        ysub,
    input  logic              hflip,
    input  logic              vflip,
    input  logic [PW-1:0]     pal,
    output logic [CW+4:0]     rom_addr,
    output logic              rom_cs,
    input  logic              rom_ok,
    input  logic [31:0]       rom_data,
    output logic [AW-1:0]     buf_addr,
    output logic [PW+3:0]     buf_din,
    output logic              buf_we
);

    localparam int PC_W = $clog2(PIX_PER_WORD);
    localparam logic [PC_W-1:0] LAST_PIX = PC_W'(PIX_PER_WORD - 1);

    state_t            state_reg;
    logic [CW-1:0]     code_reg;
    logic [3:0]        row_reg;
    logic              hflip_reg;
    logic [PW-1:0]     pal_reg;
    logic              half_reg;
    logic              first_reg;
    logic [AW-1:0]     cnt_reg;
    logic [PC_W-1:0]   pix_reg;

    logic              sr_load;
    logic              sr_shift;
    logic [PIX_W-1:0]  nibble;

    // The first FETCH cycle never honours rom_ok: it may still be the previous answer
    assign sr_load  = (state_reg == ST_FETCH) && !first_reg && rom_ok;
    assign sr_shift = (state_reg == ST_DRAW) && (pix_reg != LAST_PIX);

    jtframe_obj_draw_shift u_shift (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (sr_load),
        .shift  (sr_shift),
        .rev    (hflip_reg),
        .din    (rom_data),
        .nibble (nibble)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
            rom_cs    <= 1'b0;
            rom_addr  <= '0;
            buf_we    <= 1'b0;
            buf_addr  <= '0;
            buf_din   <= '0;
            code_reg  <= '0;
            row_reg   <= '0;
            hflip_reg <= 1'b0;
            pal_reg   <= '0;
            half_reg  <= 1'b0;
            first_reg <= 1'b0;
            cnt_reg   <= '0;
            pix_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (draw) begin
                        code_reg  <= code;
                        row_reg   <= ysub ^ {4{vflip}};
                        hflip_reg <= hflip;
                        pal_reg   <= pal;
                        half_reg  <= hflip;
                        cnt_reg   <= xpos;
                        rom_addr  <= {code, ysub ^ {4{vflip}}, hflip};
                        rom_cs    <= 1'b1;
                        busy      <= 1'b1;
                        first_reg <= 1'b1;
                        state_reg <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    first_reg <= 1'b0;
                    if (sr_load) begin
                        rom_cs    <= 1'b0;
                        buf_we    <= 1'b1;
                        buf_addr  <= cnt_reg;
                        buf_din   <= {pal_reg, nibble};
                        cnt_reg   <= cnt_reg + 1'b1;
                        pix_reg   <= '0;
                        state_reg <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    if (pix_reg == LAST_PIX) begin
                        buf_we <= 1'b0;
                        // The second word is the one whose half differs from hflip
                        if (half_reg != hflip_reg) begin
                            busy      <= 1'b0;
                            state_reg <= ST_IDLE;
                        end else begin
                            half_reg  <= ~half_reg;
                            rom_addr  <= {code_reg, row_reg, ~half_reg};
                            rom_cs    <= 1'b1;
                            first_reg <= 1'b1;
                            state_reg <= ST_FETCH;
                        end
                    end else begin
                        buf_addr <= cnt_reg;
                        buf_din  <= {pal_reg, nibble};
                        cnt_reg  <= cnt_reg + 1'b1;
                        pix_reg  <= pix_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
